// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame store.
package fb_pkg;

  typedef enum logic [1:0] {
    WRITING   = 2'd0,
    WAIT_SWAP = 2'd1,
    SWAPPED   = 2'd2
  } t_fb_state;

  localparam int unsigned FB_DEPTH = 57600;

  localparam logic [1:0] FB_BUSY    = 2'b00;
  localparam logic [1:0] FB_DONE    = 2'b01;
  localparam logic [1:0] FB_SWAPPED = 2'b11;

endpackage

// File: rtl/fb_bram.sv
// Simple dual-port frame RAM: one write port, one read port with a 2-cycle registered read.
module fb_bram
  import fb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [15:0] i_waddr,
  input  logic [7:0]  i_wdata,
  input  logic [15:0] i_raddr,
  output logic [7:0]  o_rdata
);

  logic [7:0] r_mem [FB_DEPTH];
  logic [7:0] r_rd_stage;
  logic [7:0] r_rdata;

  // Synchronous write; the caller guarantees the address is in range.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Two read register stages so the array can map onto a BRAM with output register.
  always_ff @(posedge i_clk) begin
    r_rd_stage <= r_mem[i_raddr];
    r_rdata    <= r_rd_stage;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/double_frame_buffer.sv
// Double-buffered 320x180 frame store, scanned out upscaled to 1280x720.
// States:
//   WRITING   | accepting the ray sweep into the back buffer, status 00
//   WAIT_SWAP | sweep complete, writes ignored until next frame start, status 01
//   SWAPPED   | buffers just exchanged, one cycle, writes accepted, status 11
module double_frame_buffer
  import fb_pkg::*;
#(
  parameter int SCREEN_WIDTH       = 320,
  parameter int SCREEN_HEIGHT      = 180,
  parameter int FULL_SCREEN_WIDTH  = 1280,
  parameter int FULL_SCREEN_HEIGHT = 720,
  parameter int SCALE_SHIFT        = 2
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        ray_valid_in,
  input  logic [15:0] ray_address_in,
  input  logic [7:0]  ray_pixel_in,
  input  logic        ray_last_pixel_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        active_draw_in,
  input  logic        new_frame_in,
  output logic [1:0]  fb_ready_to_switch_out,
  output logic [7:0]  pixel_out
);

  localparam logic [15:0] WR_LIMIT = 16'(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam logic [10:0] H_LIMIT  = 11'(FULL_SCREEN_WIDTH);
  localparam logic [9:0]  V_LIMIT  = 10'(FULL_SCREEN_HEIGHT);

  t_fb_state   r_state;
  t_fb_state   w_next_state;
  logic        w_toggle;
  logic        r_wr_sel;
  logic [1:0]  r_status;
  logic [1:0]  w_status;
  logic        w_wr_en;
  logic [15:0] w_x;
  logic [15:0] w_y;
  logic [15:0] w_rd_addr;
  logic [15:0] r_rd_addr;
  logic [2:0]  r_active;
  logic        w_active;
  logic [7:0]  w_rd0;
  logic [7:0]  w_rd1;

  assign w_wr_en = ray_valid_in && (r_state != WAIT_SWAP) && (ray_address_in < WR_LIMIT);

  // Next-state and swap decision; a last pixel in WRITING wins over a same-cycle frame start.
  always_comb begin
    w_next_state = r_state;
    w_toggle     = 1'b0;
    w_status     = FB_BUSY;
    case (r_state)
      WRITING: begin
        w_status = FB_BUSY;
        if (ray_valid_in && ray_last_pixel_in) w_next_state = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        w_status = FB_DONE;
        if (new_frame_in) begin
          w_next_state = SWAPPED;
          w_toggle     = 1'b1;
        end
      end
      SWAPPED: begin
        w_status     = FB_SWAPPED;
        w_next_state = WRITING;
      end
      default: begin
        w_status     = FB_BUSY;
        w_next_state = WRITING;
      end
    endcase
  end

  // State, buffer select and registered status (status lags state by one cycle).
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state  <= WRITING;
      r_wr_sel <= 1'b0;
      r_status <= FB_BUSY;
    end else begin
      r_state  <= w_next_state;
      r_status <= w_status;
      if (w_toggle) r_wr_sel <= ~r_wr_sel;
    end
  end

  // Downscale display coordinates; y*320 as (y<<8)+(y<<6).
  always_comb begin
    w_x       = 16'(hcount_in >> SCALE_SHIFT);
    w_y       = 16'(vcount_in >> SCALE_SHIFT);
    w_rd_addr = w_x + (w_y << 8) + (w_y << 6);
  end

  assign w_active = active_draw_in && (hcount_in < H_LIMIT) && (vcount_in < V_LIMIT);

  // Read address register plus 3-deep visibility pipeline matching the BRAM latency.
  always_ff @(posedge pixel_clk_in) begin
    r_rd_addr <= w_rd_addr;
    if (rst_in) r_active <= 3'b000;
    else        r_active <= {r_active[1:0], w_active};
  end

  fb_bram u_buf0 (
    .i_clk   (pixel_clk_in),
    .i_we    (w_wr_en && !r_wr_sel),
    .i_waddr (ray_address_in),
    .i_wdata (ray_pixel_in),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rd0)
  );

  fb_bram u_buf1 (
    .i_clk   (pixel_clk_in),
    .i_we    (w_wr_en && r_wr_sel),
    .i_waddr (ray_address_in),
    .i_wdata (ray_pixel_in),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rd1)
  );

  assign fb_ready_to_switch_out = r_status;
  assign pixel_out = r_active[2] ? (r_wr_sel ? w_rd0 : w_rd1) : 8'h00;

endmodule

// File: tb/tb_double_frame_buffer.sv
// Directed bench for double_frame_buffer.
module tb_double_frame_buffer;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        ray_valid_in = 1'b0;
  logic [15:0] ray_address_in = '0;
  logic [7:0]  ray_pixel_in = '0;
  logic        ray_last_pixel_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        active_draw_in = 1'b0;
  logic        new_frame_in = 1'b0;
  logic [1:0]  fb_ready_to_switch_out;
  logic [7:0]  pixel_out;

  int total = 0;
  int bad = 0;

  double_frame_buffer dut (
    .pixel_clk_in           (pixel_clk_in),
    .rst_in                 (rst_in),
    .ray_valid_in           (ray_valid_in),
    .ray_address_in         (ray_address_in),
    .ray_pixel_in           (ray_pixel_in),
    .ray_last_pixel_in      (ray_last_pixel_in),
    .hcount_in              (hcount_in),
    .vcount_in              (vcount_in),
    .active_draw_in         (active_draw_in),
    .new_frame_in           (new_frame_in),
    .fb_ready_to_switch_out (fb_ready_to_switch_out),
    .pixel_out              (pixel_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  task automatic tick();
    @(posedge pixel_clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic last);
    ray_valid_in      = 1'b1;
    ray_address_in    = a;
    ray_pixel_in      = d;
    ray_last_pixel_in = last;
    tick();
    ray_valid_in      = 1'b0;
    ray_last_pixel_in = 1'b0;
  endtask

  task automatic rd(input int h, input int v, input logic act, input logic [7:0] exp, input string tag);
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    active_draw_in = act;
    tick(); tick(); tick();
    chk(tag, pixel_out, exp);
  endtask

  task automatic pulse_frame();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
  endtask

  initial begin
    // reset
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
    chk("rst_status", {6'd0, fb_ready_to_switch_out}, 8'h00);
    chk("rst_pixel", pixel_out, 8'h00);
    chk("rst_wrsel", {7'd0, dut.r_wr_sel}, 8'h00);

    // basic write then swap (buffer 0)
    wr(16'd0, 8'h97, 1'b0);
    wr(16'd57599, 8'hdc, 1'b1);
    chk("b_stat_lag", {6'd0, fb_ready_to_switch_out}, 8'h00);
    tick();
    chk("b_stat_done", {6'd0, fb_ready_to_switch_out}, 8'h01);
    pulse_frame();
    chk("b_stat_done2", {6'd0, fb_ready_to_switch_out}, 8'h01);
    tick();
    chk("b_stat_swapped", {6'd0, fb_ready_to_switch_out}, 8'h03);
    tick();
    chk("b_stat_busy", {6'd0, fb_ready_to_switch_out}, 8'h00);
    rd(0, 0, 1'b1, 8'h97, "b_rd_origin");
    rd(1279, 719, 1'b1, 8'hdc, "b_rd_corner");

    // second sweep into buffer 1, with out-of-range write and ignored write in WAIT_SWAP
    wr(16'd5, 8'h55, 1'b0);
    wr(16'd60000, 8'hee, 1'b0);
    wr(16'd320, 8'h11, 1'b0);
    wr(16'd321, 8'h2a, 1'b0);
    wr(16'd322, 8'h33, 1'b0);
    wr(16'd6, 8'h66, 1'b1);
    tick();
    chk("u_stat_done", {6'd0, fb_ready_to_switch_out}, 8'h01);
    wr(16'd5, 8'hff, 1'b0);
    pulse_frame();
    tick(); tick();
    chk("u_wrsel", {7'd0, dut.r_wr_sel}, 8'h00);
    for (int v = 4; v < 8; v++)
      for (int h = 4; h < 8; h++)
        rd(h, v, 1'b1, 8'h2a, $sformatf("u_blk_%0d_%0d", h, v));
    rd(3, 4, 1'b1, 8'h11, "u_left");
    rd(8, 4, 1'b1, 8'h33, "u_right");
    rd(20, 0, 1'b1, 8'h55, "u_ignored_wr");
    rd(24, 0, 1'b1, 8'h66, "u_last_px");

    // simultaneous last pixel and new frame (writes buffer 0)
    ray_valid_in = 1'b1; ray_address_in = 16'd7; ray_pixel_in = 8'h77;
    ray_last_pixel_in = 1'b1; new_frame_in = 1'b1;
    tick();
    ray_valid_in = 1'b0; ray_last_pixel_in = 1'b0; new_frame_in = 1'b0;
    tick();
    chk("s_stat_done", {6'd0, fb_ready_to_switch_out}, 8'h01);
    chk("s_no_swap", {7'd0, dut.r_wr_sel}, 8'h00);
    tick();
    chk("s_still_done", {6'd0, fb_ready_to_switch_out}, 8'h01);
    pulse_frame();
    tick();
    chk("s_stat_swapped", {6'd0, fb_ready_to_switch_out}, 8'h03);
    chk("s_swap", {7'd0, dut.r_wr_sel}, 8'h01);
    rd(28, 0, 1'b1, 8'h77, "s_rd_new");
    rd(0, 0, 1'b1, 8'h97, "s_rd_old");

    // blanking and 3-cycle pipeline depth
    rd(0, 0, 1'b0, 8'h00, "k_blank");
    active_draw_in = 1'b1;
    tick(); tick();
    chk("k_depth2", pixel_out, 8'h00);
    tick();
    chk("k_depth3", pixel_out, 8'h97);

    // reset mid-sweep while in WAIT_SWAP
    wr(16'd8, 8'h88, 1'b1);
    tick();
    chk("r_pre_done", {6'd0, fb_ready_to_switch_out}, 8'h01);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("r_status", {6'd0, fb_ready_to_switch_out}, 8'h00);
    chk("r_pixel", pixel_out, 8'h00);
    chk("r_wrsel", {7'd0, dut.r_wr_sel}, 8'h00);
    pulse_frame();
    tick();
    chk("r_nf_ignored", {6'd0, fb_ready_to_switch_out}, 8'h00);
    chk("r_nf_wrsel", {7'd0, dut.r_wr_sel}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
